// File: rtl/conv_window_buf.sv
// Streaming K x K sliding-window generator with stride, flush and frame-end marker.
// Define CONV_WINDOW_BUF_POS_EN to add the out_row/out_col output-map coordinate ports.
module conv_window_buf #(
    parameter int unsigned WIDTH     = 28,
    parameter int unsigned HEIGHT    = 28,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned K         = 3,
    parameter int unsigned STRIDE    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     valid_in,
    input  logic [DATA_BITS-1:0]     data_in,
    output logic [K*K*DATA_BITS-1:0] data_out,
    output logic                     valid_out,
    output logic                     last_out
`ifdef CONV_WINDOW_BUF_POS_EN
    ,
    output logic [(((HEIGHT-K)/STRIDE+1) > 1 ? $clog2((HEIGHT-K)/STRIDE+1) : 1)-1:0] out_row,
    output logic [(((WIDTH-K)/STRIDE+1) > 1 ? $clog2((WIDTH-K)/STRIDE+1) : 1)-1:0]   out_col
`endif
);
    localparam int unsigned OUT_W  = (WIDTH - K) / STRIDE + 1;
    localparam int unsigned OUT_H  = (HEIGHT - K) / STRIDE + 1;
    localparam int unsigned CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned PW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int unsigned LAST_R = (OUT_H - 1) * STRIDE + K - 1;
    localparam int unsigned LAST_C = (OUT_W - 1) * STRIDE + K - 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] cph_q, cph_d, rph_q, rph_d;
    logic          accept, col_last, row_last, hit, is_last;

    logic [DATA_BITS-1:0]     tap   [K];
    logic [DATA_BITS-1:0]     win_q [K*K];
    logic [DATA_BITS-1:0]     win_d [K*K];
    logic [K*K*DATA_BITS-1:0] win_flat;
    logic [K*K*DATA_BITS-1:0] data_q;
    logic                     valid_q, last_q;

    // Line buffer j holds row r-K+1+j; the oldest row falls off the top of the chain.
    generate
        if (K > 1) begin : g_lb
            logic [DATA_BITS-1:0] lb_q [K-1][WIDTH];
            always_ff @(posedge clk) begin
                if (accept) begin
                    for (int j = 0; j + 2 < K; j++) lb_q[j][col_q] <= lb_q[j+1][col_q];
                    lb_q[K-2][col_q] <= data_in;
                end
            end
            always_comb begin
                for (int j = 0; j + 1 < K; j++) tap[j] = lb_q[j][col_q];
                tap[K-1] = data_in;
            end
        end else begin : g_nolb
            always_comb tap[0] = data_in;
        end
    endgenerate

    always_comb begin
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx + 1 < K; kx++) win_d[ky*K+kx] = win_q[ky*K+kx+1];
            win_d[ky*K+K-1] = tap[ky];
        end
        for (int i = 0; i < K * K; i++) win_flat[i*DATA_BITS +: DATA_BITS] = win_d[i];
    end

    always_ff @(posedge clk) begin
        if (accept) win_q <= win_d;
    end

    // Stride phases stay at 0 until the counter reaches K-1, then count down from STRIDE-1.
    always_comb begin
        accept   = valid_in & ~flush;
        col_last = (col_q == CW'(WIDTH - 1));
        row_last = (row_q == RW'(HEIGHT - 1));
        hit      = (int'(col_q) + 1 >= int'(K)) && (int'(row_q) + 1 >= int'(K)) &&
                   (cph_q == '0) && (rph_q == '0);
        is_last  = hit && (col_q == CW'(LAST_C)) && (row_q == RW'(LAST_R));

        col_d = col_last ? '0 : col_q + 1'b1;
        if (col_last || (int'(col_q) + 1 < int'(K))) cph_d = '0;
        else if (cph_q == '0)                        cph_d = PW'(STRIDE - 1);
        else                                         cph_d = cph_q - 1'b1;

        row_d = row_q;
        rph_d = rph_q;
        if (col_last) begin
            row_d = row_last ? '0 : row_q + 1'b1;
            if (row_last || (int'(row_q) + 1 < int'(K))) rph_d = '0;
            else if (rph_q == '0)                        rph_d = PW'(STRIDE - 1);
            else                                         rph_d = rph_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            cph_q   <= '0;
            rph_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= accept & hit;
            last_q  <= accept & is_last;
            if (flush) begin
                col_q <= '0;
                row_q <= '0;
                cph_q <= '0;
                rph_q <= '0;
            end else if (accept) begin
                col_q <= col_d;
                row_q <= row_d;
                cph_q <= cph_d;
                rph_q <= rph_d;
                if (hit) data_q <= win_flat;
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign last_out  = last_q;

`ifdef CONV_WINDOW_BUF_POS_EN
    localparam int unsigned ORW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int unsigned OCW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    // n*_q is the coordinate the next window will carry; o*_q is what is presented.
    logic [ORW-1:0] nrow_q, orow_q;
    logic [OCW-1:0] ncol_q, ocol_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nrow_q <= '0;
            ncol_q <= '0;
            orow_q <= '0;
            ocol_q <= '0;
        end else if (flush) begin
            nrow_q <= '0;
            ncol_q <= '0;
        end else if (accept && hit) begin
            orow_q <= nrow_q;
            ocol_q <= ncol_q;
            if (ncol_q == OCW'(OUT_W - 1)) begin
                ncol_q <= '0;
                nrow_q <= (nrow_q == ORW'(OUT_H - 1)) ? '0 : nrow_q + 1'b1;
            end else begin
                ncol_q <= ncol_q + 1'b1;
            end
        end
    end

    assign out_row = orow_q;
    assign out_col = ocol_q;
`endif

endmodule
